// File: rtl/vedic_mul_pipe_if.sv
// rtl/vedic_mul_pipe_if.sv - Operand/result handshake bundle for vedic_mul_pipe
interface vedic_mul_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               in_signed;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_result;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/vedic_mul_pipe.sv
// rtl/vedic_mul_pipe.sv - Pipelined Urdhva-Tiryagbhyam multiplier, one pair per cycle, global stall
// Define VEDIC_MUL_SIGNED_EN to honour in_signed (sign-magnitude around the unsigned core).
module vedic_mul_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  vedic_mul_pipe_if.slave io
);
  localparam int D  = WIDTH / 4;
  localparam int LV = $clog2(D);
  localparam int NW = (LV > 0) ? LV : 1;

  // 4x4 vertical-and-crosswise: every a[i]&b[j] lands in column i+j
  function automatic logic [7:0] leaf4(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        acc += 8'(a[i] & b[j]) << (i + j);
    return acc;
  endfunction

  logic                 stall;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic                 in_neg;
  logic                 neg_last;
  logic [LV:0]          vld_q;
  logic [TAG_W-1:0]     tag_q [LV+1];
  logic [NW-1:0]        neg_q;

  assign stall        = io.out_valid && !io.out_ready;
  assign io.in_ready  = !stall;
  assign io.out_valid = vld_q[LV];
  assign io.out_tag   = tag_q[LV];

`ifdef VEDIC_MUL_SIGNED_EN
  // -2^(W-1) negates to itself, which read as unsigned is already the right magnitude
  assign a_mag  = (io.in_signed && io.in_a[WIDTH-1]) ? -io.in_a : io.in_a;
  assign b_mag  = (io.in_signed && io.in_b[WIDTH-1]) ? -io.in_b : io.in_b;
  assign in_neg = io.in_signed && (io.in_a[WIDTH-1] ^ io.in_b[WIDTH-1]);
`else
  assign a_mag  = io.in_a;
  assign b_mag  = io.in_b;
  assign in_neg = io.in_signed & 1'b0;
`endif

  if (LV == 0) begin : g_neg0
    assign neg_last = in_neg;
  end else begin : g_negn
    assign neg_last = neg_q[LV-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      neg_q <= '0;
      for (int k = 0; k <= LV; k++) tag_q[k] <= '0;
    end else if (!stall) begin
      vld_q[0] <= io.in_valid;
      tag_q[0] <= io.in_tag;
      neg_q[0] <= in_neg;
      for (int k = 1; k <= LV; k++) begin
        vld_q[k] <= vld_q[k-1];
        tag_q[k] <= tag_q[k-1];
      end
      for (int k = 1; k < NW; k++) neg_q[k] <= neg_q[k-1];
    end
  end

  // Stage k holds (D>>k)^2 block products; block (i,j) covers a-digit group i, b-digit group j
  for (genvar k = 0; k <= LV; k++) begin : g_stg
    localparam int BW  = 4 << k;
    localparam int PW  = 2 * BW;
    localparam int CNT = D >> k;

    logic [PW-1:0] nxt  [CNT][CNT];
    logic [PW-1:0] prod [CNT][CNT];

    if (k == 0) begin : g_leaf
      always_comb begin
        for (int i = 0; i < CNT; i++)
          for (int j = 0; j < CNT; j++)
            nxt[i][j] = leaf4(a_mag[4*i +: 4], b_mag[4*j +: 4]);
      end
    end else begin : g_merge
      always_comb begin
        for (int i = 0; i < CNT; i++)
          for (int j = 0; j < CNT; j++)
            nxt[i][j] = {g_stg[k-1].prod[2*i+1][2*j+1], g_stg[k-1].prod[2*i][2*j]}
                      + ((PW'(g_stg[k-1].prod[2*i+1][2*j]) + PW'(g_stg[k-1].prod[2*i][2*j+1]))
                         << (BW / 2));
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < CNT; i++)
          for (int j = 0; j < CNT; j++)
            prod[i][j] <= '0;
      end else if (!stall) begin
        for (int i = 0; i < CNT; i++)
          for (int j = 0; j < CNT; j++)
            prod[i][j] <= (k == LV && neg_last) ? -nxt[i][j] : nxt[i][j];
      end
    end
  end

  assign io.out_result = g_stg[LV].prod[0][0];
endmodule

// File: tb/tb_vedic_mul_pipe.sv
// tb/tb_vedic_mul_pipe.sv - Vector-table and scoreboard bench for vedic_mul_pipe (WIDTH=32)
module tb_vedic_mul_pipe;
  localparam int WIDTH = 32;
  localparam int TAG_W = 4;
  localparam int LAT   = 1 + $clog2(WIDTH / 4);
  localparam int NVEC  = 12;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] res;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic [3:0]  tag;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vedic_mul_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();
  vedic_mul_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .io(bus));

  exp_t sb[$];
  vec_t vt[NVEC];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_out = 0;
  int   cyc   = 0;
  bit   chk_lat = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
`ifdef VEDIC_MUL_SIGNED_EN
    if (s) p = longint'($signed(a)) * longint'($signed(b));
`endif
    return p;
  endfunction

  // Called at negedge with inputs set; both transfers happen at the following posedge
  task automatic sample(input exp_t cand, output bit acc);
    exp_t e;
    #1;
    acc = bus.in_valid && bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got %h tag %h with nothing pending", bus.out_result, bus.out_tag);
      end else begin
        e = sb.pop_front();
        check("result", bus.out_result, e.res);
        check("tag", 64'(bus.out_tag), 64'(e.tag));
        if (chk_lat) check("latency", 64'(cyc - e.cyc), 64'(LAT));
      end
    end
    if (acc) begin
      cand.cyc = cyc;
      sb.push_back(cand);
    end
  endtask

  task automatic next();
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle();
    exp_t c;
    bit acc;
    c = '{res: '0, tag: '0, cyc: 0};
    bus.in_valid = 1'b0;
    sample(c, acc);
    next();
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [3:0] tag, input logic [63:0] res, input bit chk_rdy);
    exp_t c;
    bit acc;
    acc = 1'b0;
    c = '{res: res, tag: tag, cyc: 0};
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_signed = s; bus.in_tag = tag;
    for (int t = 0; t < 50 && !acc; t++) begin
      sample(c, acc);
      if (chk_rdy && t == 0) check("in_ready_streaming", 64'(bus.in_ready), 64'd1);
      next();
    end
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got in_ready %b expected 1", bus.in_ready);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 50 && sb.size() > 0; c++) idle();
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin : main
    logic [31:0] a, b;
    logic        s;
    logic [63:0] held_r;
    logic [3:0]  held_t;
    exp_t        c;
    bit          acc;
    int          k, n0;

    vt[0]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001};
    vt[1]  = '{32'h00000000, 32'h00000000, 1'b0, 64'h0000000000000000};
    vt[2]  = '{32'h00000000, 32'hFFFFFFFF, 1'b0, 64'h0000000000000000};
    vt[3]  = '{32'h00000001, 32'hFFFFFFFF, 1'b0, 64'h00000000FFFFFFFF};
    vt[4]  = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000};
    vt[6]  = '{32'hFFFFFFFD, 32'h00000005, 1'b0, 64'h00000004FFFFFFF1};
    vt[9]  = '{32'h0000FFFF, 32'h0000FFFF, 1'b0, 64'h00000000FFFE0001};
    vt[10] = '{32'hF0F0F0F0, 32'h00000010, 1'b0, 64'h0000000F0F0F0F00};
`ifdef VEDIC_MUL_SIGNED_EN
    vt[5]  = '{32'hFFFFFFFD, 32'h00000005, 1'b1, 64'hFFFFFFFFFFFFFFF1};
    vt[7]  = '{32'h80000000, 32'h00000002, 1'b1, 64'hFFFFFFFF00000000};
    vt[8]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001};
    vt[11] = '{32'h00000007, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFFFFFFFFF9};
`else
    vt[5]  = '{32'hFFFFFFFD, 32'h00000005, 1'b1, 64'h00000004FFFFFFF1};
    vt[7]  = '{32'h80000000, 32'h00000002, 1'b1, 64'h0000000100000000};
    vt[8]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFE00000001};
    vt[11] = '{32'h00000007, 32'hFFFFFFFF, 1'b1, 64'h00000006FFFFFFF9};
`endif

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_signed = 1'b0; bus.in_tag = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_out_result", bus.out_result, 64'd0);
    check("reset_out_tag", 64'(bus.out_tag), 64'd0);
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    next();

    // Single max*max, then table back-to-back with latency tracked per result
    bus.out_ready = 1'b1;
    chk_lat = 1'b1;
    drive(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 4'd5, 64'hFFFFFFFE00000001, 1'b1);
    drain();
    for (int i = 0; i < NVEC; i++)
      drive(vt[i].a, vt[i].b, vt[i].s, 4'(i), vt[i].res, 1'b1);
    drain();

    // 100 random pairs back-to-back
    n0 = n_out;
    for (int i = 0; i < 100; i++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      drive(a, b, s, 4'(i % 16), model(a, b, s), 1'b1);
    end
    drain();
    check("random_count", 64'(n_out - n0), 64'd100);

    // Stream of 8 with out_ready low for 3 cycles mid-stream
    chk_lat = 1'b0;
    n0 = n_out;
    k = 0;
    a = $urandom; b = $urandom;
    for (int t = 0; t < 60 && (k < 8 || sb.size() > 0); t++) begin
      bus.out_ready = !(t >= 5 && t < 8);
      bus.in_valid = (k < 8);
      bus.in_a = a; bus.in_b = b; bus.in_signed = 1'b0; bus.in_tag = 4'(k + 8);
      c = '{res: model(a, b, 1'b0), tag: 4'(k + 8), cyc: 0};
      sample(c, acc);
      if (t == 5) begin
        held_r = bus.out_result;
        held_t = bus.out_tag;
        check("stall_out_valid", 64'(bus.out_valid), 64'd1);
      end
      if (t >= 5 && t < 8) check("stall_in_ready", 64'(bus.in_ready), 64'd0);
      if (t == 6 || t == 7) begin
        check("stall_hold_result", bus.out_result, held_r);
        check("stall_hold_tag", 64'(bus.out_tag), 64'(held_t));
      end
      if (acc) begin
        k++;
        a = $urandom; b = $urandom;
      end
      next();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    check("stall_accepted", 64'(k), 64'd8);
    check("stall_count", 64'(n_out - n0), 64'd8);
    drain();

    // Reset with one result presented and three more in flight
    chk_lat = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom;
      drive(a, b, 1'b0, 4'(i + 1), model(a, b, 1'b0), 1'b1);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("pre_reset_valid", 64'(bus.out_valid), 64'd1);
    check("pre_reset_tag", 64'(bus.out_tag), 64'd1);
    rst = 1'b1;
    #1;
    check("async_reset_valid", 64'(bus.out_valid), 64'd0);
    check("async_reset_result", bus.out_result, 64'd0);
    check("async_reset_tag", 64'(bus.out_tag), 64'd0);
    sb.delete();
    next();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) idle();
    check("post_reset_outputs", 64'(n_out), 64'(n_out));
    drive(32'h12345678, 32'h0000ABCD, 1'b0, 4'd9, model(32'h12345678, 32'h0000ABCD, 1'b0), 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
